dma_req_gen: RTL and testbench
==============================

DMA_REQ_GEN -- requirements
Module: dma_req_gen

Interface
REQ-001 Parameter CL_ADDR_WIDTH, default 64, sets the width of cache-line addresses and counts.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 start  in  1  one-cycle transfer request; sampled only in IDLE.
REQ-005 size  in  CL_ADDR_WIDTH  number of cache lines to transfer; latched on accepted start.
REQ-006 rd_base, wr_base  in  CL_ADDR_WIDTH each  first source and destination cache-line addresses; latched on accepted start.
REQ-007 rd_req_full, wr_req_full  in  1 each  request-queue backpressure; high blocks issue.
REQ-008 rd_rsp_valid, wr_rsp_valid  in  1 each  one completed read or write response per high cycle.
REQ-009 rd_req_valid, wr_req_valid  out  1 each  registered one-cycle request strobes.
REQ-010 rd_req_addr, wr_req_addr  out  CL_ADDR_WIDTH each  registered request addresses; valid only with the matching strobe.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse on transfer completion.

Function
REQ-013 States SHALL be IDLE, READ, READ_WAIT, WRITE, WRITE_WAIT, DONE; the encoding is 3 bits.
REQ-014 In IDLE, when start=1: latch size, rd_base, wr_base; clear all four counters (rd_iss, rd_rsp, wr_iss, wr_rsp); go to READ, or go to DONE if size=0.
REQ-015 In READ, at each edge where rd_req_full=0, drive rd_req_valid=1 next cycle with rd_req_addr=rd_base+rd_iss (modulo 2^CL_ADDR_WIDTH), then increment rd_iss.
REQ-016 In READ, when rd_req_full=1, rd_req_valid SHALL be 0 next cycle and rd_iss SHALL hold.
REQ-017 When the edge issues the request that makes rd_iss equal size, go to READ_WAIT.
REQ-018 In READ and READ_WAIT, each rd_rsp_valid=1 increments rd_rsp. rd_rsp_valid is ignored in every other state and once rd_rsp equals size.
REQ-019 Leave READ_WAIT for WRITE on the edge where rd_rsp reaches size. Responses arriving while still in READ are counted, so all reads may complete before READ_WAIT is entered; in that case, exit READ_WAIT on the next edge.
REQ-020 WRITE, WRITE_WAIT, wr_req_*, wr_iss and wr_rsp SHALL mirror REQ-015..REQ-019 using wr_base, wr_req_full and wr_rsp_valid.
REQ-021 From WRITE_WAIT, go to DONE when wr_rsp reaches size.
REQ-022 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-023 start SHALL be ignored in every state except IDLE.
REQ-024 No read request is issued after entering WRITE, and no write request is issued before it.
REQ-025 Counters are CL_ADDR_WIDTH bits; size=2^CL_ADDR_WIDTH-1 SHALL complete without overflow.

Reset
REQ-026 While rst_n=0: state=IDLE; all counters 0; rd_req_valid, wr_req_valid, busy and done all 0; both addresses 0.
REQ-027 Reset asserted mid-transfer SHALL abort immediately with no done pulse; outstanding responses arriving after reset are ignored in IDLE.
REQ-028 The first edge after rst_n deasserts SHALL sample start normally.

Verification
REQ-029 size=4, rd_base=0x100, wr_base=0x200, no backpressure, each response 3 cycles after its request -> read addresses 0x100..0x103 on consecutive cycles, then write addresses 0x200..0x203, then a single done pulse.
REQ-030 size=3 with rd_req_full high for 5 cycles after the first read -> exactly 3 reads, no strobe during the full cycles, addresses contiguous.
REQ-031 size=0 start -> busy high for 1 cycle, done pulse, no request strobes.
REQ-032 rd_base=2^64-2, size=3 -> read addresses FFFF_FFFF_FFFF_FFFE, FFFF_FFFF_FFFF_FFFF, 0.
REQ-033 Reset pulsed after 2 of 4 writes -> outputs all 0 immediately and no done; a new start with size=1 then completes normally.
REQ-034 start held high throughout a size=2 transfer -> exactly one transfer, plus a new transfer starting on the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/dma_req_gen.sv
// Cache-line DMA request generator: issues size read requests, waits for all read
// responses, then issues size write requests, waits for all write responses, pulses done.
module dma_req_gen #(
  parameter int CL_ADDR_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CL_ADDR_WIDTH-1:0] size,
  input  logic [CL_ADDR_WIDTH-1:0] rd_base,
  input  logic [CL_ADDR_WIDTH-1:0] wr_base,
  input  logic                     rd_req_full,
  input  logic                     wr_req_full,
  input  logic                     rd_rsp_valid,
  input  logic                     wr_rsp_valid,
  output logic                     rd_req_valid,
  output logic [CL_ADDR_WIDTH-1:0] rd_req_addr,
  output logic                     wr_req_valid,
  output logic [CL_ADDR_WIDTH-1:0] wr_req_addr,
  output logic                     busy,
  output logic                     done
);

  localparam logic [CL_ADDR_WIDTH-1:0] ONE = CL_ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ       = 3'd1,
    READ_WAIT  = 3'd2,
    WRITE      = 3'd3,
    WRITE_WAIT = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [CL_ADDR_WIDTH-1:0] size_r, rd_base_r, wr_base_r;
  logic [CL_ADDR_WIDTH-1:0] rd_iss, rd_rsp, wr_iss, wr_rsp;

  logic accept;
  logic rd_issue, wr_issue;
  logic rd_rsp_inc, wr_rsp_inc;
  logic rd_last_iss, wr_last_iss;
  logic rd_all_rsp, wr_all_rsp;

  always_comb begin
    accept      = (state == IDLE) && start;
    rd_issue    = (state == READ) && !rd_req_full;
    wr_issue    = (state == WRITE) && !wr_req_full;
    // Responses past the expected count are dropped so the counters cannot run beyond size.
    rd_rsp_inc  = ((state == READ) || (state == READ_WAIT)) && rd_rsp_valid && (rd_rsp != size_r);
    wr_rsp_inc  = ((state == WRITE) || (state == WRITE_WAIT)) && wr_rsp_valid && (wr_rsp != size_r);
    rd_last_iss = (rd_iss + ONE) == size_r;
    wr_last_iss = (wr_iss + ONE) == size_r;
    rd_all_rsp  = (rd_rsp == size_r) || (rd_rsp_inc && ((rd_rsp + ONE) == size_r));
    wr_all_rsp  = (wr_rsp == size_r) || (wr_rsp_inc && ((wr_rsp + ONE) == size_r));

    state_nx = state;
    unique case (state)
      IDLE:       if (start) state_nx = (size == '0) ? DONE : READ;
      READ:       if (rd_issue && rd_last_iss) state_nx = READ_WAIT;
      READ_WAIT:  if (rd_all_rsp) state_nx = WRITE;
      WRITE:      if (wr_issue && wr_last_iss) state_nx = WRITE_WAIT;
      WRITE_WAIT: if (wr_all_rsp) state_nx = DONE;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase

    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Transfer parameters are only consulted after an accepted start, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      size_r    <= size;
      rd_base_r <= rd_base;
      wr_base_r <= wr_base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_iss <= '0;
      rd_rsp <= '0;
      wr_iss <= '0;
      wr_rsp <= '0;
    end else if (accept) begin
      rd_iss <= '0;
      rd_rsp <= '0;
      wr_iss <= '0;
      wr_rsp <= '0;
    end else begin
      if (rd_issue)   rd_iss <= rd_iss + ONE;
      if (rd_rsp_inc) rd_rsp <= rd_rsp + ONE;
      if (wr_issue)   wr_iss <= wr_iss + ONE;
      if (wr_rsp_inc) wr_rsp <= wr_rsp + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      wr_req_valid <= 1'b0;
      wr_req_addr  <= '0;
    end else begin
      rd_req_valid <= rd_issue;
      wr_req_valid <= wr_issue;
      if (rd_issue) rd_req_addr <= rd_base_r + rd_iss;
      if (wr_issue) wr_req_addr <= wr_base_r + wr_iss;
    end
  end

endmodule

// File: tb/tb_dma_req_gen.sv
// Bench for dma_req_gen: directed scenarios plus randomized transfers with random
// backpressure and response latency, checked against an address-list reference model.
module tb_dma_req_gen;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] size, rd_base, wr_base;
  logic         rd_req_full, wr_req_full;
  logic         rd_rsp_valid = 1'b0;
  logic         wr_rsp_valid = 1'b0;
  logic         rd_req_valid, wr_req_valid, busy, done;
  logic [W-1:0] rd_req_addr, wr_req_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] rd_log[$];
  logic [W-1:0] wr_log[$];
  int           rd_cyc[$];
  int           wr_cyc[$];
  int           busy_cnt = 0;
  int           done_cnt = 0;
  bit           done_prev = 1'b0;
  bit           wr_phase = 1'b0;
  int           rd_pend[$];
  int           wr_pend[$];
  int           rsp_fixed = 3;

  dma_req_gen #(.CL_ADDR_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .size         (size),
    .rd_base      (rd_base),
    .wr_base      (wr_base),
    .rd_req_full  (rd_req_full),
    .wr_req_full  (wr_req_full),
    .rd_rsp_valid (rd_rsp_valid),
    .wr_rsp_valid (wr_rsp_valid),
    .rd_req_valid (rd_req_valid),
    .rd_req_addr  (rd_req_addr),
    .wr_req_valid (wr_req_valid),
    .wr_req_addr  (wr_req_addr),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: logs strobes and checks ordering/backpressure rules one step after each edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rd_req_valid) begin
      chk("rd_strobe_while_full", 64'(rd_req_full), 64'd0);
      chk("rd_after_write", 64'(wr_phase), 64'd0);
      rd_log.push_back(rd_req_addr);
      rd_cyc.push_back(cyc);
    end
    if (wr_req_valid) begin
      chk("wr_strobe_while_full", 64'(wr_req_full), 64'd0);
      wr_phase = 1'b1;
      wr_log.push_back(wr_req_addr);
      wr_cyc.push_back(cyc);
    end
    if (busy) busy_cnt++;
    if (done) begin
      chk("done_single_cycle", 64'(done_prev), 64'd0);
      done_cnt++;
      wr_phase = 1'b0;
    end
    done_prev = done;
  end

  function automatic int rsp_delay();
    if (rsp_fixed > 0) return rsp_fixed;
    return int'($urandom_range(6, 1));
  endfunction

  // Memory responder: one response per request, in order, after a chosen latency.
  always @(negedge clk) begin
    rd_rsp_valid = 1'b0;
    wr_rsp_valid = 1'b0;
    foreach (rd_pend[i]) rd_pend[i]--;
    foreach (wr_pend[i]) wr_pend[i]--;
    if (rd_pend.size() > 0 && rd_pend[0] <= 0) begin
      rd_rsp_valid = 1'b1;
      void'(rd_pend.pop_front());
    end
    if (wr_pend.size() > 0 && wr_pend[0] <= 0) begin
      wr_rsp_valid = 1'b1;
      void'(wr_pend.pop_front());
    end
    if (rd_req_valid) rd_pend.push_back(rsp_delay());
    if (wr_req_valid) wr_pend.push_back(rsp_delay());
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    rd_cyc.delete();
    wr_cyc.delete();
    busy_cnt = 0;
    done_cnt = 0;
    wr_phase = 1'b0;
  endtask

  // bp: 0 none, 1 random on both queues, 2 read queue full for 5 cycles after the first read.
  task automatic do_xfer(input logic [W-1:0] sz, input logic [W-1:0] rb, input logic [W-1:0] wb,
                         input int bp, input bit rel_rst);
    int  fcnt = 0;
    int  n = 0;
    bit  seen = 1'b0;
    bit  ok = 1'b0;
    clear_logs();
    size = sz;
    rd_base = rb;
    wr_base = wb;
    start = 1'b1;
    if (rel_rst) rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_accepted_busy", 64'(busy), 64'd1);
    while (n < 400 && !ok) begin
      if (done) ok = 1'b1;
      if (rd_req_valid) seen = 1'b1;
      case (bp)
        1: begin
          rd_req_full = ($urandom_range(3, 0) == 0);
          wr_req_full = ($urandom_range(3, 0) == 0);
        end
        2: begin
          rd_req_full = seen && (fcnt < 5);
          wr_req_full = 1'b0;
          if (rd_req_full) fcnt++;
        end
        default: begin
          rd_req_full = 1'b0;
          wr_req_full = 1'b0;
        end
      endcase
      @(negedge clk);
      n++;
    end
    rd_req_full = 1'b0;
    wr_req_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("xfer_completes", 64'(ok), 64'd1);
  endtask

  // Reference model: addresses are the base plus the line index, wrapping at 2^W.
  task automatic check_lists(input string tag, input logic [W-1:0] sz,
                             input logic [W-1:0] rb, input logic [W-1:0] wb);
    chk({tag, "_rd_count"}, 64'(rd_log.size()), sz);
    chk({tag, "_wr_count"}, 64'(wr_log.size()), sz);
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    for (int i = 0; i < rd_log.size(); i++) chk({tag, "_rd_addr"}, rd_log[i], rb + W'(i));
    for (int i = 0; i < wr_log.size(); i++) chk({tag, "_wr_addr"}, wr_log[i], wb + W'(i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rsz, rrb, rwb;
    logic [W-1:0] wrap_hi;
    int n, wcnt;

    rst_n = 1'b0;
    start = 1'b0;
    size = '0;
    rd_base = '0;
    wr_base = '0;
    rd_req_full = 1'b0;
    wr_req_full = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_rd_valid", 64'(rd_req_valid), 64'd0);
    chk("reset_wr_valid", 64'(wr_req_valid), 64'd0);
    chk("reset_rd_addr", rd_req_addr, 64'd0);
    chk("reset_wr_addr", wr_req_addr, 64'd0);

    // Start on the very first edge after reset release; basic 4-line copy.
    rsp_fixed = 3;
    do_xfer(64'd4, 64'h100, 64'h200, 0, 1'b1);
    check_lists("basic", 64'd4, 64'h100, 64'h200);
    for (int i = 1; i < rd_cyc.size(); i++) chk("basic_rd_consecutive", 64'(rd_cyc[i] - rd_cyc[0]), 64'(i));
    for (int i = 1; i < wr_cyc.size(); i++) chk("basic_wr_consecutive", 64'(wr_cyc[i] - wr_cyc[0]), 64'(i));
    if (rd_cyc.size() > 0 && wr_cyc.size() > 0)
      chk("basic_wr_after_rd", 64'(wr_cyc[0] > rd_cyc[rd_cyc.size()-1]), 64'd1);

    // Read backpressure for 5 cycles after the first read.
    do_xfer(64'd3, 64'h40, 64'h80, 2, 1'b0);
    check_lists("bp", 64'd3, 64'h40, 64'h80);
    if (rd_cyc.size() >= 2) chk("bp_read_gap", 64'(rd_cyc[1] - rd_cyc[0]), 64'd6);

    // Zero-length transfer.
    do_xfer(64'd0, 64'h10, 64'h20, 0, 1'b0);
    check_lists("zero", 64'd0, 64'h10, 64'h20);
    chk("zero_busy_cycles", 64'(busy_cnt), 64'd1);

    // Address wrap at the top of the address space.
    wrap_hi = 64'hFFFF_FFFF_FFFF_FFFE;
    do_xfer(64'd3, wrap_hi, 64'h0, 0, 1'b0);
    check_lists("wrap", 64'd3, wrap_hi, 64'h0);
    if (rd_log.size() == 3) begin
      chk("wrap_rd1", rd_log[1], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wrap_rd2", rd_log[2], 64'h0);
    end

    // Randomized transfers with random backpressure and response latency.
    rsp_fixed = 0;
    for (int t = 0; t < 6; t++) begin
      rsz = W'($urandom_range(10, 1));
      rrb = {$urandom, $urandom};
      rwb = {$urandom, $urandom};
      if (t == 0) rrb = '1 - W'(2);
      do_xfer(rsz, rrb, rwb, 1, 1'b0);
      check_lists("rand", rsz, rrb, rwb);
    end

    // Reset mid-write: abort with no done, then a fresh transfer.
    rsp_fixed = 3;
    clear_logs();
    size = 64'd4;
    rd_base = 64'h500;
    wr_base = 64'h600;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    wcnt = 0;
    while (n < 200 && wcnt < 2) begin
      @(negedge clk);
      if (wr_req_valid) wcnt++;
      n++;
    end
    chk("abort_two_writes", 64'(wcnt), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_rd_valid", 64'(rd_req_valid), 64'd0);
    chk("abort_wr_valid", 64'(wr_req_valid), 64'd0);
    chk("abort_rd_addr", rd_req_addr, 64'd0);
    chk("abort_wr_addr", wr_req_addr, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_wr_total", 64'(wr_log.size()), 64'd2);
    do_xfer(64'd1, 64'h700, 64'h800, 0, 1'b0);
    check_lists("after_abort", 64'd1, 64'h700, 64'h800);

    // start held high: one transfer, then a new one right after IDLE is re-entered.
    clear_logs();
    size = 64'd2;
    rd_base = 64'h300;
    wr_base = 64'h400;
    start = 1'b1;
    n = 0;
    while (n < 200 && done_cnt == 0) begin
      @(negedge clk);
      n++;
    end
    chk("held_first_done", 64'(done_cnt), 64'd1);
    chk("held_first_rd", 64'(rd_log.size()), 64'd2);
    chk("held_first_wr", 64'(wr_log.size()), 64'd2);
    @(negedge clk);
    chk("held_idle_reentered", 64'(busy), 64'd0);
    @(negedge clk);
    chk("held_restart", 64'(busy), 64'd1);
    start = 1'b0;
    n = 0;
    while (n < 200 && done_cnt < 2) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("held_second_done", 64'(done_cnt), 64'd2);
    chk("held_total_rd", 64'(rd_log.size()), 64'd4);
    chk("held_total_wr", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < rd_log.size(); i++) chk("held_rd_addr", rd_log[i], 64'h300 + W'(i % 2));
    for (int i = 0; i < wr_log.size(); i++) chk("held_wr_addr", wr_log[i], 64'h400 + W'(i % 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
